exec_wb_stage: RTL and testbench

//  Execute/writeback stage directly upstream of the 8x8-bit register file.
//  - Accepts one decoded op per handshake with operands already read from the register file.
//  - Computes an 8-bit result or a condition bit.
//  - Drives the register-file write port (data and CB) from flops only, so strobes are glitch-free.
//  - Multiply is multi-cycle (shift-add); every other op completes in one cycle.

---
 rtl/exec_pkg.sv | 37 +++
 rtl/exec_mul_seq.sv | 53 +++++
 rtl/exec_wb_stage.sv | 153 +++++++++++++++
 tb/tb_exec_wb_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the execute/writeback stage and the decode stage that feeds it.
package exec_pkg;

  // Datapath width, matching the 8x8-bit register file.
  localparam int DW      = 8;
  // Register address width (8 registers).
  localparam int AW      = 3;
  // Shift-add iterations for multiply; one multiplier bit is consumed per cycle.
  localparam int MUL_CYC = DW;
  // Width of the multiplier iteration counter.
  localparam int MUL_CW  = $clog2(MUL_CYC);
  // Width of the shift amount taken from operand B.
  localparam int SHW     = $clog2(DW);

  // Opcode encodings shared with decode.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_MUL  = 4'd7,
    OP_CMOV = 4'd8,
    OP_SLT  = 4'd9,
    OP_SEQ  = 4'd10
  } op_e;

  // Stage control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

endpackage

// File: rtl/exec_mul_seq.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, low DW bits of the product kept.
module exec_mul_seq
  import exec_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic          o_done,
  output logic [DW-1:0] o_prod
);

  logic              r_run;
  logic [MUL_CW-1:0] r_cnt;
  logic [DW-1:0]     r_mcand;
  logic [DW-1:0]     r_mplier;
  logic [DW-1:0]     r_acc;
  logic [DW-1:0]     w_sum;
  logic              w_last;

  // Partial sum for this iteration; presented as the product so the final sum is usable the same cycle.
  assign w_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last = (r_cnt == MUL_CW'(MUL_CYC - 1));
  assign o_done = r_run && w_last;
  assign o_prod = w_sum;

  // Load operands on start, then accumulate and shift once per cycle until the last iteration.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run    <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_run    <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_run) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + MUL_CW'(1);
      if (w_last) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/exec_wb_stage.sv
// Execute/writeback stage feeding the register-file write port; all write-port outputs come from flops.
module exec_wb_stage
  import exec_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          issue_valid_i,
  output logic          issue_ready_o,
  input  logic [3:0]    op_i,
  input  logic [AW-1:0] dest_addr_i,
  input  logic [DW-1:0] rs_data_i,
  input  logic [DW-1:0] rt_data_i,
  input  logic          cb_i,
  output logic          write_o,
  output logic [AW-1:0] write_addr_o,
  output logic [DW-1:0] write_data_o,
  output logic          write_CB_o,
  output logic          cb_data_o,
  output logic          busy_o
);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [AW-1:0] r_dest;

  logic          r_write;
  logic [AW-1:0] r_write_addr;
  logic [DW-1:0] r_write_data;
  logic          r_write_cb;
  logic          r_cb_data;

  logic          w_accept;
  logic          w_is_mul;
  logic          w_mul_done;
  logic [DW-1:0] w_mul_prod;

  logic [DW-1:0]  w_alu_result;
  logic           w_alu_we;
  logic           w_alu_cbwe;
  logic           w_alu_cb;
  logic [SHW-1:0] w_shamt;

  assign issue_ready_o = (r_state != ST_MUL);
  assign busy_o        = (r_state == ST_MUL);
  assign w_accept      = issue_valid_i && issue_ready_o;
  assign w_is_mul      = (op_i == OP_MUL);
  assign w_shamt       = rt_data_i[SHW-1:0];

  assign write_o      = r_write;
  assign write_addr_o = r_write_addr;
  assign write_data_o = r_write_data;
  assign write_CB_o   = r_write_cb;
  assign cb_data_o    = r_cb_data;

  exec_mul_seq u_mul (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_start (w_accept && w_is_mul),
    .i_a     (rs_data_i),
    .i_b     (rt_data_i),
    .o_done  (w_mul_done),
    .o_prod  (w_mul_prod)
  );

  // Single-cycle ALU on the operands presented at acceptance; decides which strobe (if any) fires.
  always_comb begin
    w_alu_result = '0;
    w_alu_we     = 1'b0;
    w_alu_cbwe   = 1'b0;
    w_alu_cb     = 1'b0;
    case (op_i)
      OP_ADD:  begin w_alu_result = rs_data_i + rt_data_i;  w_alu_we = 1'b1; end
      OP_SUB:  begin w_alu_result = rs_data_i - rt_data_i;  w_alu_we = 1'b1; end
      OP_AND:  begin w_alu_result = rs_data_i & rt_data_i;  w_alu_we = 1'b1; end
      OP_OR:   begin w_alu_result = rs_data_i | rt_data_i;  w_alu_we = 1'b1; end
      OP_XOR:  begin w_alu_result = rs_data_i ^ rt_data_i;  w_alu_we = 1'b1; end
      OP_SLL:  begin w_alu_result = rs_data_i << w_shamt;   w_alu_we = 1'b1; end
      OP_SRL:  begin w_alu_result = rs_data_i >> w_shamt;   w_alu_we = 1'b1; end
      OP_CMOV: begin w_alu_result = rs_data_i;              w_alu_we = cb_i; end
      OP_SLT:  begin w_alu_cb = ($signed(rs_data_i) < $signed(rt_data_i)); w_alu_cbwe = 1'b1; end
      OP_SEQ:  begin w_alu_cb = (rs_data_i == rt_data_i);   w_alu_cbwe = 1'b1; end
      default: begin end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: multiply parks in MUL until the multiplier finishes; everything else passes through WB.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_WB: begin
        if (w_accept) begin
          w_state_nxt = w_is_mul ? ST_MUL : ST_WB;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (w_mul_done) begin
          w_state_nxt = ST_WB;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Hold the destination of an accepted op for the multi-cycle multiply writeback.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dest <= '0;
    end else if (w_accept) begin
      r_dest <= dest_addr_i;
    end
  end

  // Write-port flops: strobes pulse for the WB cycle only, address/data/CB value hold between writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_write      <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
      r_write_cb   <= 1'b0;
      r_cb_data    <= 1'b0;
    end else begin
      r_write    <= 1'b0;
      r_write_cb <= 1'b0;
      if (w_accept && !w_is_mul) begin
        if (w_alu_we) begin
          r_write      <= 1'b1;
          r_write_addr <= dest_addr_i;
          r_write_data <= w_alu_result;
        end
        if (w_alu_cbwe) begin
          r_write_cb <= 1'b1;
          r_cb_data  <= w_alu_cb;
        end
      end else if ((r_state == ST_MUL) && w_mul_done) begin
        r_write      <= 1'b1;
        r_write_addr <= r_dest;
        r_write_data <= w_mul_prod;
      end
    end
  end

endmodule

// File: tb/tb_exec_wb_stage.sv
// Self-checking bench for exec_wb_stage: directed spec cases followed by randomized ops against a reference model.
module tb_exec_wb_stage;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       issue_valid_i;
  logic       issue_ready_o;
  logic [3:0] op_i;
  logic [2:0] dest_addr_i;
  logic [7:0] rs_data_i;
  logic [7:0] rt_data_i;
  logic       cb_i;
  logic       write_o;
  logic [2:0] write_addr_o;
  logic [7:0] write_data_o;
  logic       write_CB_o;
  logic       cb_data_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  // Expected held write-port values.
  logic [2:0] eAddr;
  logic [7:0] eData;
  logic       eCb;

  // Expectation for the op most recently issued.
  bit         pWe;
  bit         pCbWe;
  logic [2:0] pAddr;
  logic [7:0] pData;
  bit         pCb;
  int         pOp;

  exec_wb_stage dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .issue_valid_i (issue_valid_i),
    .issue_ready_o (issue_ready_o),
    .op_i          (op_i),
    .dest_addr_i   (dest_addr_i),
    .rs_data_i     (rs_data_i),
    .rt_data_i     (rt_data_i),
    .cb_i          (cb_i),
    .write_o       (write_o),
    .write_addr_o  (write_addr_o),
    .write_data_o  (write_data_o),
    .write_CB_o    (write_CB_o),
    .cb_data_o     (cb_data_o),
    .busy_o        (busy_o)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: what the op should write, computed with plain integer arithmetic.
  function automatic void model(input int op, input int a, input int b, input bit cb,
                                output bit we, output bit cbwe, output int data, output bit cbv);
    int sa;
    int sb;
    we   = 0;
    cbwe = 0;
    data = 0;
    cbv  = 0;
    sa   = (a >= 128) ? a - 256 : a;
    sb   = (b >= 128) ? b - 256 : b;
    case (op)
      0:  begin we = 1; data = (a + b) % 256; end
      1:  begin we = 1; data = (a - b + 256) % 256; end
      2:  begin we = 1; data = a & b; end
      3:  begin we = 1; data = a | b; end
      4:  begin we = 1; data = a ^ b; end
      5:  begin we = 1; data = (a * (1 << (b % 8))) % 256; end
      6:  begin we = 1; data = a / (1 << (b % 8)); end
      7:  begin we = 1; data = (a * b) % 256; end
      8:  begin we = cb; data = a; end
      9:  begin cbwe = 1; cbv = (sa < sb); end
      10: begin cbwe = 1; cbv = (a == b); end
      default: begin end
    endcase
  endfunction

  task automatic applyStimulus(input int op, input int a, input int b, input int d, input bit cb);
    int tmp;
    issue_valid_i = 1'b1;
    op_i          = op[3:0];
    rs_data_i     = a[7:0];
    rt_data_i     = b[7:0];
    dest_addr_i   = d[2:0];
    cb_i          = cb;
    model(op, a, b, cb, pWe, pCbWe, tmp, pCb);
    pData = tmp[7:0];
    pAddr = d[2:0];
    pOp   = op;
  endtask

  // Drop valid and scramble the operand inputs so captured values are what matter.
  task automatic releaseInputs();
    issue_valid_i = 1'b0;
    op_i          = 4'($urandom_range(0, 15));
    rs_data_i     = 8'($urandom);
    rt_data_i     = 8'($urandom);
    dest_addr_i   = 3'($urandom);
    cb_i          = 1'($urandom);
  endtask

  task automatic checkOutput(input string tag);
    if (pWe) begin
      eAddr = pAddr;
      eData = pData;
    end
    if (pCbWe) begin
      eCb = pCb;
    end
    checkVal({tag, ".write"},   32'(write_o),      32'(pWe));
    checkVal({tag, ".writeCB"}, 32'(write_CB_o),   32'(pCbWe));
    checkVal({tag, ".addr"},    32'(write_addr_o), 32'(eAddr));
    checkVal({tag, ".data"},    32'(write_data_o), 32'(eData));
    checkVal({tag, ".cb"},      32'(cb_data_o),    32'(eCb));
  endtask

  task automatic checkIdle(input string tag);
    checkVal({tag, ".write"},   32'(write_o),      32'(0));
    checkVal({tag, ".writeCB"}, 32'(write_CB_o),   32'(0));
    checkVal({tag, ".addr"},    32'(write_addr_o), 32'(eAddr));
    checkVal({tag, ".data"},    32'(write_data_o), 32'(eData));
    checkVal({tag, ".cb"},      32'(cb_data_o),    32'(eCb));
    checkVal({tag, ".ready"},   32'(issue_ready_o), 32'(1));
    checkVal({tag, ".busy"},    32'(busy_o),       32'(0));
  endtask

  // Issue one op, wait out any multiply, and check the writeback cycle.
  task automatic runOp(input string tag, input int op, input int a, input int b, input int d, input bit cb);
    applyStimulus(op, a, b, d, cb);
    tick();
    releaseInputs();
    if (op == 7) begin
      for (int i = 0; i < 8; i++) begin
        checkVal({tag, ".mulReady"}, 32'(issue_ready_o), 32'(0));
        checkVal({tag, ".mulBusy"},  32'(busy_o),        32'(1));
        checkVal({tag, ".mulWrite"}, 32'(write_o),       32'(0));
        tick();
      end
    end
    checkOutput(tag);
  endtask

  task automatic resetExpect();
    eAddr = '0;
    eData = '0;
    eCb   = 1'b0;
  endtask

  initial begin
    rst_ni        = 1'b0;
    issue_valid_i = 1'b0;
    op_i          = '0;
    dest_addr_i   = '0;
    rs_data_i     = '0;
    rt_data_i     = '0;
    cb_i          = 1'b0;
    resetExpect();
    tick();
    tick();
    checkIdle("reset");
    rst_ni = 1'b1;
    tick();

    // ADD with wraparound.
    runOp("add", 0, 8'hF0, 8'h20, 3, 1'b0);
    checkVal("add.spec", 32'(write_data_o), 32'h10);

    // Asynchronous reset mid-cycle while a strobe is high.
    #3;
    rst_ni = 1'b0;
    #1;
    resetExpect();
    checkIdle("asyncReset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Back-to-back XOR, SUB, SLL.
    applyStimulus(4, 8'hA5, 8'h3C, 1, 1'b0);
    tick();
    checkOutput("b2b.xor");
    applyStimulus(1, 8'h10, 8'h25, 2, 1'b0);
    tick();
    checkOutput("b2b.sub");
    applyStimulus(5, 8'h81, 8'h0B, 4, 1'b0);
    tick();
    checkOutput("b2b.sll");
    releaseInputs();
    tick();
    checkIdle("b2b.idle");

    // Multiply.
    runOp("mul", 7, 8'h0D, 8'h0B, 5, 1'b0);
    checkVal("mul.spec", 32'(write_data_o), 32'h8F);

    // Compares.
    runOp("slt", 9, 8'hFF, 8'h01, 6, 1'b0);
    checkVal("slt.spec", 32'(cb_data_o), 32'(1));
    runOp("seq", 10, 8'h05, 8'h06, 6, 1'b1);
    checkVal("seq.spec", 32'(cb_data_o), 32'(0));

    // Conditional move.
    runOp("cmov0", 8, 8'h5A, 8'h00, 7, 1'b0);
    runOp("cmov1", 8, 8'h5A, 8'h00, 7, 1'b1);
    checkVal("cmov1.spec", 32'(write_data_o), 32'h5A);

    // Reset while a multiply is in flight: no write, then normal service.
    tick();
    applyStimulus(7, 8'hFF, 8'hFF, 2, 1'b0);
    tick();
    releaseInputs();
    tick();
    tick();
    #2;
    rst_ni = 1'b0;
    #1;
    resetExpect();
    checkIdle("mulReset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checkIdle("mulReset.after");
    end
    runOp("postReset", 0, 8'h12, 8'h34, 1, 1'b0);

    // Randomized ops including illegal opcodes, with and without idle gaps.
    for (int n = 0; n < 80; n++) begin
      runOp("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 7)), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        tick();
        checkIdle("rand.idle");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
